// File: rtl/vpu_pkg.sv
// Shared vector-unit types for the operand-fetch sequencer.
package vpu_pkg;

   typedef enum logic [2:0] {
      OF_IDLE = 3'd0,
      OF_RD2  = 3'd1,
      OF_RD1  = 3'd2,
      OF_CAP  = 3'd3,
      OF_OUT  = 3'd4
   } ofetch_state_e;

   typedef logic [1:0] lmul_t;

   localparam int VREG_ADDR_W = 5;
   typedef logic [VREG_ADDR_W-1:0] vreg_addr_t;

   // Index of the final register in a group of 1<<lmul registers.
   function automatic logic [2:0] group_last_idx(input lmul_t lmul);
      logic [3:0] sz;
      sz = 4'd1 << lmul;
      return 3'(sz - 4'd1);
   endfunction

endpackage

// File: rtl/vreg_operand_fetch.sv
// Walks an issued instruction's LMUL register group, reading vs2 (and vs1)
// from regMemory and presenting each operand pair over valid/ready.
module vreg_operand_fetch
   import vpu_pkg::*;
#(
   parameter int WIDTH      = 512,
   parameter int REG_COUNT  = 32,
   parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  issue_valid,
   output logic                  issue_ready,
   input  logic [ADDR_WIDTH-1:0] issue_vs1,
   input  logic [ADDR_WIDTH-1:0] issue_vs2,
   input  logic [ADDR_WIDTH-1:0] issue_vd,
   input  logic                  issue_use_vs1,
   input  logic [1:0]            issue_lmul,
   output logic                  rf_read_en,
   output logic [ADDR_WIDTH-1:0] rf_read_addr,
   input  logic [WIDTH-1:0]      rf_read_data,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [WIDTH-1:0]      op_vs1_data,
   output logic [WIDTH-1:0]      op_vs2_data,
   output logic [ADDR_WIDTH-1:0] op_vd,
   output logic [2:0]            op_idx,
   output logic                  op_last
);

   ofetch_state_e         state_q, state_d;
   logic [2:0]            idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] vs1_q, vs1_d;
   logic [ADDR_WIDTH-1:0] vs2_q, vs2_d;
   logic [ADDR_WIDTH-1:0] vd_q, vd_d;
   logic                  use_vs1_q, use_vs1_d;
   lmul_t                 lmul_q, lmul_d;
   logic [WIDTH-1:0]      opnd1_q, opnd1_d;
   logic [WIDTH-1:0]      opnd2_q, opnd2_d;

   logic [ADDR_WIDTH-1:0] idx_ext;
   logic                  at_last;

   assign idx_ext = ADDR_WIDTH'(idx_q);
   assign at_last = (idx_q == group_last_idx(lmul_q));

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      vs1_d     = vs1_q;
      vs2_d     = vs2_q;
      vd_d      = vd_q;
      use_vs1_d = use_vs1_q;
      lmul_d    = lmul_q;
      opnd1_d   = opnd1_q;
      opnd2_d   = opnd2_q;

      // Flush overrides every transition and drops any read in flight.
      if (flush) begin
         state_d = OF_IDLE;
         idx_d   = 3'd0;
      end else begin
         unique case (state_q)
            OF_IDLE: begin
               if (issue_valid) begin
                  vs1_d     = issue_vs1;
                  vs2_d     = issue_vs2;
                  vd_d      = issue_vd;
                  use_vs1_d = issue_use_vs1;
                  lmul_d    = issue_lmul;
                  idx_d     = 3'd0;
                  state_d   = OF_RD2;
               end
            end
            OF_RD2: begin
               state_d = use_vs1_q ? OF_RD1 : OF_CAP;
            end
            OF_RD1: begin
               opnd2_d = rf_read_data;
               state_d = OF_CAP;
            end
            OF_CAP: begin
               if (use_vs1_q) begin
                  opnd1_d = rf_read_data;
               end else begin
                  opnd2_d = rf_read_data;
                  opnd1_d = '0;
               end
               state_d = OF_OUT;
            end
            OF_OUT: begin
               if (op_ready) begin
                  if (at_last) begin
                     idx_d   = 3'd0;
                     state_d = OF_IDLE;
                  end else begin
                     idx_d   = idx_q + 3'd1;
                     state_d = OF_RD2;
                  end
               end
            end
            default: begin
               state_d = OF_IDLE;
               idx_d   = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= OF_IDLE;
         idx_q     <= 3'd0;
         vs1_q     <= '0;
         vs2_q     <= '0;
         vd_q      <= '0;
         use_vs1_q <= 1'b0;
         lmul_q    <= '0;
         opnd1_q   <= '0;
         opnd2_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         vs1_q     <= vs1_d;
         vs2_q     <= vs2_d;
         vd_q      <= vd_d;
         use_vs1_q <= use_vs1_d;
         lmul_q    <= lmul_d;
         opnd1_q   <= opnd1_d;
         opnd2_q   <= opnd2_d;
      end
   end

   // Register-file address wraps modulo REG_COUNT through truncation.
   always_comb begin
      rf_read_en   = 1'b0;
      rf_read_addr = '0;
      if (state_q == OF_RD2) begin
         rf_read_en   = 1'b1;
         rf_read_addr = vs2_q + idx_ext;
      end else if (state_q == OF_RD1) begin
         rf_read_en   = 1'b1;
         rf_read_addr = vs1_q + idx_ext;
      end
   end

   assign issue_ready = (state_q == OF_IDLE);
   assign op_valid    = (state_q == OF_OUT);
   assign op_vs1_data = opnd1_q;
   assign op_vs2_data = opnd2_q;
   assign op_vd       = vd_q + idx_ext;
   assign op_idx      = idx_q;
   assign op_last     = op_valid && at_last;

endmodule

// File: tb/tb_vreg_operand_fetch.sv
// Randomized and directed bench for vreg_operand_fetch against a group-level model.
module tb_vreg_operand_fetch;

   localparam int WIDTH = 512;
   localparam int REG_COUNT = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst, flush, issue_valid, issue_ready, issue_use_vs1;
   logic [AW-1:0] issue_vs1, issue_vs2, issue_vd;
   logic [1:0] issue_lmul;
   logic rf_read_en;
   logic [AW-1:0] rf_read_addr;
   logic [WIDTH-1:0] rf_read_data;
   logic op_valid, op_ready, op_last;
   logic [WIDTH-1:0] op_vs1_data, op_vs2_data;
   logic [AW-1:0] op_vd;
   logic [2:0] op_idx;

   logic rnd_ready, rnd_bit, ready_dir;
   assign op_ready = rnd_ready ? rnd_bit : ready_dir;

   always #5 clk = ~clk;

   vreg_operand_fetch #(.WIDTH(WIDTH), .REG_COUNT(REG_COUNT), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_vs1(issue_vs1), .issue_vs2(issue_vs2), .issue_vd(issue_vd),
      .issue_use_vs1(issue_use_vs1), .issue_lmul(issue_lmul),
      .rf_read_en(rf_read_en), .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_vs1_data(op_vs1_data), .op_vs2_data(op_vs2_data),
      .op_vd(op_vd), .op_idx(op_idx), .op_last(op_last)
   );

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] rand_word();
      logic [WIDTH-1:0] w;
      for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // regMemory stand-in: one-cycle read latency, garbage when not reading.
   logic [WIDTH-1:0] mem [REG_COUNT];
   always @(posedge clk) begin
      rf_read_data <= rf_read_en ? mem[rf_read_addr] : rand_word();
      rnd_bit <= ($urandom_range(0, 3) != 0);
   end

   typedef struct {
      logic [WIDTH-1:0] vs1;
      logic [WIDTH-1:0] vs2;
      logic [AW-1:0] vd;
      logic [2:0] idx;
      logic last;
      int lat;
   } pair_t;

   pair_t exp_q[$];
   logic [AW-1:0] addr_q[$];

   // Group-level reference: expected read order and operand pairs.
   task automatic issue(input int vs1, input int vs2, input int vd, input bit use1, input int lmul);
      int n, w;
      pair_t p;
      w = 0;
      while (!issue_ready && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      check("issue_wait_timeout", (w >= 200), 0);
      n = 1 << lmul;
      for (int i = 0; i < n; i++) begin
         addr_q.push_back(AW'((vs2 + i) % REG_COUNT));
         if (use1) addr_q.push_back(AW'((vs1 + i) % REG_COUNT));
         p.vs2 = mem[(vs2 + i) % REG_COUNT];
         p.vs1 = use1 ? mem[(vs1 + i) % REG_COUNT] : '0;
         p.vd = AW'((vd + i) % REG_COUNT);
         p.idx = 3'(i);
         p.last = (i == n - 1);
         p.lat = use1 ? 4 : 3;
         exp_q.push_back(p);
      end
      issue_valid = 1'b1;
      issue_vs1 = AW'(vs1);
      issue_vs2 = AW'(vs2);
      issue_vd = AW'(vd);
      issue_use_vs1 = use1;
      issue_lmul = 2'(lmul);
      @(posedge clk); #1;
      issue_valid = 1'b0;
   endtask

   task automatic wait_done();
      int w;
      w = 0;
      while (!(exp_q.size() == 0 && issue_ready) && w < 3000) begin
         @(posedge clk); #1;
         w++;
      end
      check("done_timeout", (w >= 3000), 0);
   endtask

   task automatic wait_read(input int addr);
      int w;
      w = 0;
      do begin
         @(posedge clk); #1;
         w++;
      end while (!(rf_read_en && rf_read_addr == AW'(addr)) && w < 200);
      check("read_wait_timeout", (w >= 200), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_issue_ready"}, issue_ready, 1);
      check({tag, "_op_valid"}, op_valid, 0);
      check({tag, "_rf_read_en"}, rf_read_en, 0);
      check({tag, "_rf_read_addr"}, rf_read_addr, 0);
      check({tag, "_vs1_data"}, op_vs1_data, 0);
      check({tag, "_vs2_data"}, op_vs2_data, 0);
      check({tag, "_op_vd"}, op_vd, 0);
      check({tag, "_op_idx"}, op_idx, 0);
      check({tag, "_op_last"}, op_last, 0);
   endtask

   // Cycle monitor: protocol, ordering, latency and stall stability.
   bit busy = 0;
   bit valid_prev = 0;
   bit stalled_prev = 0;
   int since = 0;
   logic [WIDTH-1:0] prev_vs1, prev_vs2;
   logic [AW-1:0] prev_vd;

   always @(negedge clk) begin
      if (rst) begin
         busy = 0;
         since = 0;
         valid_prev = 0;
         stalled_prev = 0;
      end else begin
         since++;
         check("issue_ready", issue_ready, !busy);
         if (!rf_read_en) check("addr_when_idle", rf_read_addr, 0);
         if (op_valid) check("read_during_out", rf_read_en, 0);
         if (flush) begin
            busy = 0;
         end else begin
            if (rf_read_en) begin
               if (addr_q.size() == 0) check("spurious_read", rf_read_addr, 'x);
               else check("rd_addr", rf_read_addr, addr_q.pop_front());
            end
            if (op_valid) begin
               if (exp_q.size() == 0) begin
                  check("spurious_op_valid", op_valid, 0);
               end else begin
                  if (!valid_prev) check("latency", since, exp_q[0].lat);
                  if (stalled_prev) begin
                     check("stall_vs1", op_vs1_data, prev_vs1);
                     check("stall_vs2", op_vs2_data, prev_vs2);
                     check("stall_vd", op_vd, prev_vd);
                  end
                  if (op_ready) begin
                     check("vs2_data", op_vs2_data, exp_q[0].vs2);
                     check("vs1_data", op_vs1_data, exp_q[0].vs1);
                     check("op_vd", op_vd, exp_q[0].vd);
                     check("op_idx", op_idx, exp_q[0].idx);
                     check("op_last", op_last, exp_q[0].last);
                     if (exp_q[0].last) busy = 0;
                     void'(exp_q.pop_front());
                     since = 0;
                  end
               end
            end
            if (issue_valid && issue_ready) begin
               busy = 1;
               since = 0;
            end
         end
         valid_prev = op_valid;
         stalled_prev = op_valid && !op_ready && !flush;
         prev_vs1 = op_vs1_data;
         prev_vs2 = op_vs2_data;
         prev_vd = op_vd;
      end
   end

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      issue_valid = 1'b0;
      issue_vs1 = '0;
      issue_vs2 = '0;
      issue_vd = '0;
      issue_use_vs1 = 1'b0;
      issue_lmul = '0;
      rnd_ready = 1'b0;
      ready_dir = 1'b1;
      for (int i = 0; i < REG_COUNT; i++) mem[i] = rand_word();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst = 1'b0;
      @(posedge clk); #1;

      // LMUL=1 vector-vector
      issue(8, 4, 2, 1'b1, 0);
      wait_done();

      // LMUL=4, vs2 only
      issue(0, 8, 6, 1'b0, 2);
      wait_done();

      // Backpressure on pair 0
      ready_dir = 1'b0;
      issue(20, 12, 5, 1'b1, 1);
      begin
         int w;
         w = 0;
         while (!op_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
         end
         check("bp_valid_timeout", (w >= 50), 0);
      end
      repeat (5) @(posedge clk);
      #1;
      ready_dir = 1'b1;
      @(posedge clk); #1;
      check("bp_resume_en", rf_read_en, 1);
      check("bp_resume_addr", rf_read_addr, 13);
      wait_done();

      // Wrap-around group
      issue(30, 28, 29, 1'b1, 3);
      wait_done();

      // Flush in RD1 of idx 1, then immediate re-issue
      issue(16, 24, 3, 1'b1, 2);
      wait_read(17);
      flush = 1'b1;
      exp_q.delete();
      addr_q.delete();
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_issue_ready", issue_ready, 1);
      check("flush_op_valid", op_valid, 0);
      check("flush_op_idx", op_idx, 0);
      issue(2, 10, 7, 1'b0, 1);
      wait_done();

      // Async reset mid-RD1 of idx 1
      issue(9, 1, 4, 1'b1, 1);
      wait_read(10);
      rst = 1'b1;
      exp_q.delete();
      addr_q.delete();
      #1;
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      check_reset_outputs("midrst_cyc");
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_no_valid", op_valid, 0);

      // Random instructions with random backpressure
      rnd_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         issue($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               1'($urandom_range(0, 1)), $urandom_range(0, 3));
         wait_done();
      end
      rnd_ready = 1'b0;

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
